// File: rtl/image_streamer_if.sv
// Pixel stream bundle: one pixel per valid/ready transfer, with its raster
// position and end-of-line / end-of-frame markers.
interface image_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_BITS   = 8,
  parameter int COL_BITS   = 8
);
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [ROW_BITS-1:0]   row;
  logic [COL_BITS-1:0]   col;
  logic                  line_end;
  logic                  frame_end;

  // Producer side: drives the pixel and its markers, listens to ready.
  modport master (
    output pixel_out, pixel_valid, row, col, line_end, frame_end,
    input  pixel_ready
  );

  // Consumer side: observes the pixel and its markers, drives ready.
  modport slave (
    input  pixel_out, pixel_valid, row, col, line_end, frame_end,
    output pixel_ready
  );
endinterface

// File: rtl/image_streamer.sv
// Serializes a packed image frame into a raster-order pixel stream.
// Pixel 0 sits in the most significant slice of i_frame_data. Every output is
// a register, so nothing combinationally depends on pixel_ready or i_start.
module image_streamer #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 131,
  parameter int IMAGE_HEIGHT = 185,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_start,
  input  logic [DATA_WIDTH*IMAGE_HEIGHT*IMAGE_WIDTH-1:0] i_frame_data,
  image_streamer_if.master                            pix,
  output logic                                        o_busy,
  output logic                                        o_done
);

  localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int FRAME_BITS   = DATA_WIDTH * FRAME_PIXELS;
  localparam int K_BITS       = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int IDX_BITS     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [K_BITS-1:0]   LAST_K   = K_BITS'(FRAME_PIXELS - 1);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMAGE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FINISH
  } state_t;

  state_t                r_state,     w_next_state;
  logic [K_BITS-1:0]     r_k,         w_next_k;
  logic [ROW_BITS-1:0]   r_row,       w_next_row;
  logic [COL_BITS-1:0]   r_col,       w_next_col;
  logic [DATA_WIDTH-1:0] r_pixel,     w_next_pixel;
  logic                  r_valid,     w_next_valid;
  logic                  r_line_end,  w_next_line_end;
  logic                  r_frame_end, w_next_frame_end;
  logic                  r_busy,      w_next_busy;
  logic                  r_done,      w_next_done;

  logic                  w_transfer;
  logic [K_BITS-1:0]     w_sel_k;
  logic [IDX_BITS-1:0]   w_sel_base;
  logic [DATA_WIDTH-1:0] w_sel_pixel;

  assign w_transfer = r_valid && pix.pixel_ready;

  // Index of the pixel that will be presented next: 0 when a frame starts,
  // k+1 while streaming. The last pixel folds back to 0 so the slice base
  // never leaves the frame.
  assign w_sel_k     = (r_state == S_STREAM && r_k != LAST_K) ? r_k + 1'b1 : '0;
  assign w_sel_base  = IDX_BITS'((FRAME_PIXELS - 1 - int'(w_sel_k)) * DATA_WIDTH);
  assign w_sel_pixel = i_frame_data[w_sel_base +: DATA_WIDTH];

  // Next-state and next-output decode for the IDLE/STREAM/FINISH sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    w_next_state     = r_state;
    w_next_k         = r_k;
    w_next_row       = r_row;
    w_next_col       = r_col;
    w_next_pixel     = r_pixel;
    w_next_valid     = r_valid;
    w_next_line_end  = r_line_end;
    w_next_frame_end = r_frame_end;
    w_next_busy      = r_busy;
    w_next_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state     = S_STREAM;
          w_next_k         = '0;
          w_next_row       = '0;
          w_next_col       = '0;
          w_next_pixel     = w_sel_pixel;
          w_next_valid     = 1'b1;
          w_next_busy      = 1'b1;
          w_next_line_end  = (LAST_COL == '0);
          w_next_frame_end = (LAST_K == '0);
        end
      end

      S_STREAM: begin
        if (w_transfer) begin
          if (r_k == LAST_K) begin
            w_next_state     = S_FINISH;
            w_next_k         = '0;
            w_next_row       = '0;
            w_next_col       = '0;
            w_next_pixel     = '0;
            w_next_valid     = 1'b0;
            w_next_line_end  = 1'b0;
            w_next_frame_end = 1'b0;
            w_next_busy      = 1'b0;
            w_next_done      = 1'b1;
          end else begin
            w_next_k = w_sel_k;
            if (r_col == LAST_COL) begin
              w_next_col = '0;
              w_next_row = r_row + 1'b1;
            end else begin
              w_next_col = r_col + 1'b1;
            end
            w_next_pixel     = w_sel_pixel;
            w_next_line_end  = (w_next_col == LAST_COL);
            w_next_frame_end = (w_sel_k == LAST_K);
          end
        end
      end

      S_FINISH: begin
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state     = S_IDLE;
        w_next_k         = '0;
        w_next_row       = '0;
        w_next_col       = '0;
        w_next_pixel     = '0;
        w_next_valid     = 1'b0;
        w_next_line_end  = 1'b0;
        w_next_frame_end = 1'b0;
        w_next_busy      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any partial frame silently.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_pixel     <= '0;
      r_valid     <= 1'b0;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_k         <= w_next_k;
      r_row       <= w_next_row;
      r_col       <= w_next_col;
      r_pixel     <= w_next_pixel;
      r_valid     <= w_next_valid;
      r_line_end  <= w_next_line_end;
      r_frame_end <= w_next_frame_end;
      r_busy      <= w_next_busy;
      r_done      <= w_next_done;
    end
  end

  assign pix.pixel_out   = r_pixel;
  assign pix.pixel_valid = r_valid;
  assign pix.row         = r_row;
  assign pix.col         = r_col;
  assign pix.line_end    = r_line_end;
  assign pix.frame_end   = r_frame_end;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer on a 4x3 frame of 8-bit pixels. A monitor pops an
// expected-beat queue on every accepted pixel and checks stalled pixels hold.
module tb_image_streamer;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int RB = 2;
  localparam int CB = 2;
  localparam logic [DW*N-1:0] FRAME_A = 96'h0102030405060708090A0B0C;

  typedef struct packed {
    logic [DW-1:0] pixel;
    logic [RB-1:0] row;
    logic [CB-1:0] col;
    logic          line_end;
    logic          frame_end;
  } beat_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [DW*N-1:0] frame;

  beat_t exp_q[$];
  int    errors      = 0;
  int    checks      = 0;
  int    done_count  = 0;
  int    transfers   = 0;
  int    ready_mode  = 0;

  image_streamer_if #(.DATA_WIDTH(DW), .ROW_BITS(RB), .COL_BITS(CB)) pix ();

  image_streamer #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .ROW_BITS    (RB),
    .COL_BITS    (CB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_frame_data(frame),
    .pix         (pix),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
  initial begin
    int phase;
    phase = 0;
    pix.pixel_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       pix.pixel_ready = (phase == 0);
        2:       pix.pixel_ready = 1'($urandom_range(0, 1));
        default: pix.pixel_ready = 1'b1;
      endcase
      phase = (phase == 2) ? 0 : phase + 1;
    end
  end

  function automatic beat_t cur_beat();
    beat_t b;
    b.pixel     = pix.pixel_out;
    b.row       = pix.row;
    b.col       = pix.col;
    b.line_end  = pix.line_end;
    b.frame_end = pix.frame_end;
    return b;
  endfunction

  function automatic logic [DW+RB+CB+4:0] out_vec();
    return {pix.pixel_valid, pix.pixel_out, pix.row, pix.col,
            pix.line_end, pix.frame_end, busy, done};
  endfunction

  // Reference model: raster order, pixel 0 in the top slice.
  task automatic push_frame(input logic [DW*N-1:0] f);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.pixel     = f[DW*(N-k)-1 -: DW];
      b.row       = RB'(k / W);
      b.col       = CB'(k % W);
      b.line_end  = ((k % W) == W - 1);
      b.frame_end = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: scoreboard pop on each transfer, hold check on each stall.
  initial begin
    beat_t cur;
    beat_t prev;
    beat_t exp_b;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = cur_beat();
        if (prev_stall) begin
          checks++;
          if (pix.pixel_valid !== 1'b1 || cur !== prev) begin
            errors++;
            $display("FAIL hold: got valid=%b beat=%h, required valid=1 beat=%h",
                     pix.pixel_valid, cur, prev);
          end
        end
        if (pix.pixel_valid && pix.pixel_ready) begin
          transfers++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_pixel: got beat=%h, required no transfer", cur);
          end else begin
            exp_b = exp_q.pop_front();
            if (cur !== exp_b) begin
              errors++;
              $display("FAIL pixel: got beat=%h, required beat=%h", cur, exp_b);
            end
          end
        end
        if (done) done_count++;
        prev_stall = pix.pixel_valid && !pix.pixel_ready;
        prev = cur;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got done=%b after %0d cycles, required done=1", done, cycles);
    end
  endtask

  task automatic wait_pixel(input logic [DW-1:0] value);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pix.pixel_valid === 1'b1 && pix.pixel_out === value) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pixel_timeout: pixel %h never presented, required presented", value);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    frame = FRAME_A;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", out_vec());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h, required 0", out_vec());
    end
  endtask

  task automatic test_full_frame();
    int cycles;
    int d0;
    d0 = done_count;
    ready_mode = 0;
    push_frame(frame);
    pulse_start();
    checks++;
    if (pix.pixel_valid !== 1'b1 || pix.pixel_out !== 8'h01 || pix.row !== 2'd0 ||
        pix.col !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_pixel: got valid=%b pixel=%h row=%0d col=%0d busy=%b, required 1 01 0 0 1",
               pix.pixel_valid, pix.pixel_out, pix.row, pix.col, busy);
    end
    wait_done(100, cycles);
    checks++;
    if (cycles != N) begin
      errors++;
      $display("FAIL frame_cycles: got %0d, required %0d", cycles, N);
    end
    @(negedge clk);
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL after_done: got %h, required 0", out_vec());
    end
    checks++;
    if (done_count - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_frame_end: got dones=%0d left=%0d, required dones=1 left=0",
               done_count - d0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int cycles;
    int d0;
    int t0;
    d0 = done_count;
    t0 = transfers;
    ready_mode = 1;
    push_frame(frame);
    pulse_start();
    wait_done(200, cycles);
    ready_mode = 0;
    @(negedge clk);
    checks++;
    if (transfers - t0 != N || done_count - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure: got transfers=%0d dones=%0d left=%0d, required %0d 1 0",
               transfers - t0, done_count - d0, exp_q.size(), N);
    end
  endtask

  task automatic test_start_while_busy();
    int cycles;
    int d0;
    d0 = done_count;
    ready_mode = 0;
    push_frame(frame);
    pulse_start();
    wait_pixel(8'h05);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, cycles);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pix.pixel_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL busy_start_restart: got valid=%b done=%b, required 0 0",
                 pix.pixel_valid, done);
      end
    end
    checks++;
    if (done_count - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_start: got dones=%0d left=%0d, required 1 0",
               done_count - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int cycles;
    int d0;
    ready_mode = 0;
    push_frame(frame);
    pulse_start();
    wait_pixel(8'h07);
    d0 = done_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h, required 0", out_vec());
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pix.pixel_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_idle: got valid=%b done=%b, required 0 0",
                 pix.pixel_valid, done);
      end
    end
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("FAIL mid_reset_done: got %0d pulses, required 0", done_count - d0);
    end
    exp_q.delete();
    push_frame(frame);
    pulse_start();
    checks++;
    if (pix.pixel_valid !== 1'b1 || pix.pixel_out !== 8'h01) begin
      errors++;
      $display("FAIL restart_first: got valid=%b pixel=%h, required 1 01",
               pix.pixel_valid, pix.pixel_out);
    end
    wait_done(100, cycles);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_frame: got %0d pixels left, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    int d0;
    bit found;
    d0 = done_count;
    ready_mode = 0;
    push_frame(frame);
    push_frame(frame);
    @(negedge clk);
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (pix.pixel_valid === 1'b1 && pix.frame_end === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL b2b_timeout: first frame end never seen, required seen");
    end
    @(negedge clk);
    checks++;
    if (pix.pixel_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap1: got valid=%b done=%b, required 0 1", pix.pixel_valid, done);
    end
    @(negedge clk);
    checks++;
    if (pix.pixel_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap2: got valid=%b done=%b, required 0 0", pix.pixel_valid, done);
    end
    @(negedge clk);
    checks++;
    if (pix.pixel_valid !== 1'b1 || pix.pixel_out !== 8'h01) begin
      errors++;
      $display("FAIL b2b_second_first: got valid=%b pixel=%h, required 1 01",
               pix.pixel_valid, pix.pixel_out);
    end
    start = 1'b0;
    wait_done(100, cycles);
    @(negedge clk);
    checks++;
    if (done_count - d0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: got dones=%0d left=%0d, required 2 0",
               done_count - d0, exp_q.size());
    end
  endtask

  task automatic test_start_and_rst();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL start_rst_outputs: got %h, required 0", out_vec());
    end
    @(negedge clk);
    checks++;
    if (pix.pixel_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_rst_idle: got valid=%b busy=%b, required 0 0",
               pix.pixel_valid, busy);
    end
  endtask

  task automatic test_random_ready();
    int cycles;
    for (int i = 0; i < N * DW / 32; i++) frame[i*32 +: 32] = $urandom;
    ready_mode = 2;
    push_frame(frame);
    pulse_start();
    wait_done(400, cycles);
    ready_mode = 0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_ready: got %0d pixels left, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame = FRAME_A;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    test_start_and_rst();
    test_random_ready();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
